// File: rtl/alu_seq_pkg.sv
// Shared opcode and state encodings for the handshaked ALU.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_NAND = 4'd5;
    localparam logic [3:0] OP_NOR  = 4'd6;
    localparam logic [3:0] OP_OR   = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_comb.sv
// Combinational WIDTH-bit datapath for the eight single-cycle ALU operations.
module alu_seq_comb
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow
);

    logic             sub;
    logic [WIDTH-1:0] bb;
    logic [WIDTH-1:0] low;
    logic [1:0]       msb;
    logic [WIDTH-1:0] sum;
    logic             ovf;

    // Split the adder at the MSB so carry[WIDTH-1] is visible for overflow.
    always_comb begin
        sub = ({1'b0, op} == OP_SUB) || ({1'b0, op} == OP_SLT);
        bb  = sub ? ~b : b;
        low = {1'b0, a[WIDTH-2:0]} + {1'b0, bb[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, sub};
        msb = {1'b0, a[WIDTH-1]} + {1'b0, bb[WIDTH-1]} + {1'b0, low[WIDTH-1]};
        sum = {msb[0], low[WIDTH-2:0]};
        ovf = msb[1] ^ low[WIDTH-1];
    end

    always_comb begin
        result   = sum;
        carryout = 1'b0;
        overflow = 1'b0;
        case ({1'b0, op})
            OP_ADD, OP_SUB: begin
                result   = sum;
                carryout = msb[1];
                overflow = ovf;
            end
            OP_XOR:  result = a ^ b;
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, msb[0] ^ ovf};
            OP_AND:  result = a & b;
            OP_NAND: result = ~(a & b);
            OP_NOR:  result = ~(a | b);
            OP_OR:   result = a | b;
            default: result = sum;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: registered result/flags with valid/ready on both sides.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier (op 8).
//
// state | meaning
// IDLE  | accepting ops; holds single-cycle results in the output register
// MUL   | shift-add iterations in progress, input stalled
// DONE  | multiply result pending until downstream takes it
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero,
    output logic             err
);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             is_mul;
    logic             is_illegal;
    logic             mul_last;

    logic [WIDTH-1:0] c_result;
    logic             c_carry;
    logic             c_ovf;
    logic [WIDTH-1:0] s_result;
    logic             s_carry;
    logic             s_ovf;

    alu_seq_comb #(.WIDTH(WIDTH)) u_comb (
        .a        (a),
        .b        (b),
        .op       (op[2:0]),
        .result   (c_result),
        .carryout (c_carry),
        .overflow (c_ovf)
    );

`ifdef ALU_SEQ_MUL_EN
    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]      mul_cnt;
    logic [2*WIDTH-1:0] mul_acc;
    logic [WIDTH-1:0]   mul_mcand;
    logic [WIDTH-1:0]   mul_mplier;
    logic [WIDTH:0]     mul_sum;

    assign is_mul   = (op == OP_MUL);
    assign mul_last = (state == MUL) && (mul_cnt == CW'(WIDTH));
    assign mul_sum  = {1'b0, mul_acc[2*WIDTH-1:WIDTH]}
                    + {1'b0, (mul_mplier[0] ? mul_mcand : {WIDTH{1'b0}})};

    // Right-shifting accumulator: the product settles after WIDTH steps.
    always_ff @(posedge clk) begin
        if (reset) begin
            mul_cnt    <= '0;
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
        end else if (accept && is_mul) begin
            mul_cnt    <= '0;
            mul_acc    <= '0;
            mul_mcand  <= a;
            mul_mplier <= b;
        end else if (state == MUL && !mul_last) begin
            mul_acc    <= {mul_sum, mul_acc[WIDTH-1:1]};
            mul_mplier <= mul_mplier >> 1;
            mul_cnt    <= mul_cnt + CW'(1);
        end
    end
`else
    assign is_mul   = 1'b0;
    assign mul_last = 1'b0;
`endif

    assign is_illegal = (op > OP_OR) && !is_mul;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && is_mul) state_nxt = MUL;
            MUL:     if (mul_last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE) && (!out_valid || out_ready);
        accept   = in_valid && in_ready;
    end

    always_comb begin
        s_result = c_result;
        s_carry  = c_carry;
        s_ovf    = c_ovf;
        if (is_illegal) begin
            s_result = '0;
            s_carry  = 1'b0;
            s_ovf    = 1'b0;
        end
    end

    // Accepting always retires any pending beat, so out_valid can be rewritten.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            carryout  <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            err       <= 1'b0;
        end else if (accept && !is_mul) begin
            out_valid <= 1'b1;
            result    <= s_result;
            carryout  <= s_carry;
            overflow  <= s_ovf;
            zero      <= (s_result == '0);
            err       <= is_illegal;
        end else if (accept) begin
            out_valid <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
        end else if (mul_last) begin
            out_valid <= 1'b1;
            result    <= mul_acc[WIDTH-1:0];
            carryout  <= 1'b0;
            overflow  <= |mul_acc[2*WIDTH-1:WIDTH];
            zero      <= (mul_acc[WIDTH-1:0] == '0);
            err       <= 1'b0;
`endif
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed vectors, monitor pops expected beats.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         carryout;
    logic         overflow;
    logic         zero;
    logic         err;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         v;
        logic         z;
        logic         e;
    } exp_t;

    exp_t sb[$];
    exp_t got_beat;
    exp_t exp_beat;
    int   total = 0;
    int   bad = 0;
    int   beats = 0;
    int   cyc = 0;
    int   t0;
    int   n;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carryout  (carryout),
        .overflow  (overflow),
        .zero      (zero),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(input logic [W-1:0] r, input logic c, input logic v,
                                input logic z, input logic e);
        return {r, c, v, z, e};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Present an op and hold it until accepted; returns just after the accept edge.
    task automatic send(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input exp_t e, input bit push);
        int k;
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout op=%0d in_ready=%b want 1", o, in_ready);
        end else if (push) begin
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        op = 4'd0;
        a = '0;
        b = '0;
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            got_beat = {result, carryout, overflow, zero, err};
            total++;
            beats++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL beat%0d unexpected: r=%h c=%b v=%b z=%b e=%b want none",
                         beats, result, carryout, overflow, zero, err);
            end else begin
                exp_beat = sb.pop_front();
                if (got_beat !== exp_beat) begin
                    bad++;
                    $display("FAIL beat%0d got r=%h c=%b v=%b z=%b e=%b want r=%h c=%b v=%b z=%b e=%b",
                             beats, result, carryout, overflow, zero, err,
                             exp_beat.r, exp_beat.c, exp_beat.v, exp_beat.z, exp_beat.e);
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 0);
        chk("rst_err", err, 0);
        @(posedge clk);
        #1;

        // Arithmetic and SLT, streamed back to back
        send(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, mk(32'h8000_0000, 0, 1, 0, 0), 1);
        send(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, mk(32'h0000_0000, 1, 0, 1, 0), 1);
        send(OP_SUB, 32'h0000_0005, 32'h0000_0005, mk(32'h0000_0000, 1, 0, 1, 0), 1);
        send(OP_SUB, 32'h0000_0000, 32'h0000_0001, mk(32'hFFFF_FFFF, 0, 0, 0, 0), 1);
        send(OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, mk(32'h0000_0001, 0, 0, 0, 0), 1);
        send(OP_SLT, 32'h8000_0000, 32'h7FFF_FFFF, mk(32'h0000_0001, 0, 0, 0, 0), 1);
        send(OP_SLT, 32'h0000_0003, 32'hFFFF_FFFE, mk(32'h0000_0000, 0, 0, 1, 0), 1);
        send(4'd12,  32'h1234_5678, 32'h9ABC_DEF0, mk(32'h0000_0000, 0, 0, 1, 1), 1);

        t0 = cyc;
        send(OP_NOR,  32'h0000_0000, 32'h0000_0000, mk(32'hFFFF_FFFF, 0, 0, 0, 0), 1);
        send(OP_OR,   32'h00FF_0000, 32'h0000_00FF, mk(32'h00FF_00FF, 0, 0, 0, 0), 1);
        send(OP_NAND, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(32'h0000_0000, 0, 0, 1, 0), 1);
        chk("stream_cycles", cyc - t0, 3);
        idle();
        @(posedge clk);
        #1;

        // Backpressure: AND result held, queued XOR waits for out_ready
        send(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, mk(32'hF000_F000, 0, 0, 0, 0), 1);
        out_ready = 1'b0;
        in_valid = 1'b1;
        op = OP_XOR;
        a = 32'h1234_5678;
        b = 32'h0F0F_0F0F;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_result", result, 32'hF000_F000);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        t0 = cyc;
        send(OP_XOR, 32'h1234_5678, 32'h0F0F_0F0F, mk(32'h1D3B_5977, 0, 0, 0, 0), 1);
        chk("bp_accept_cycle", cyc - t0, 1);
        idle();

`ifdef ALU_SEQ_MUL_EN
        send(OP_MUL, 32'h0001_0000, 32'h0001_0001, mk(32'h0001_0000, 0, 1, 0, 0), 1);
        idle();
        t0 = cyc;
        n = 0;
        @(negedge clk);
        chk("mul_in_ready", in_ready, 0);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mul_latency", cyc - t0, 33);
        @(posedge clk);
        #1;

        send(OP_MUL, 32'h0000_0007, 32'h0000_0009, mk(32'h0000_003F, 0, 0, 0, 0), 0);
        idle();
        repeat (10) @(posedge clk);
`else
        send(OP_MUL, 32'h0001_0000, 32'h0001_0001, mk(32'h0000_0000, 0, 0, 1, 1), 1);
        idle();
        @(negedge clk);
        chk("op8_latency", out_valid, 1);
        @(posedge clk);
        #1;

        out_ready = 1'b0;
        send(OP_ADD, 32'h0000_0001, 32'h0000_0001, mk(32'h0000_0002, 0, 0, 0, 0), 0);
        idle();
        repeat (3) @(posedge clk);
`endif
        // Reset aborts the in-flight op; it must never surface
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_result", result, 0);
        repeat (40) @(posedge clk);
        #1;

        send(OP_ADD, 32'h0000_0002, 32'h0000_0003, mk(32'h0000_0005, 0, 0, 0, 0), 1);
        idle();
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised-width, handshaked successor to the team's 32-bit combinational ALU.
- Supports the same eight operations: ADD, SUB, XOR, SLT, AND, NAND, NOR and OR.
- Adds the following:
  - registered outputs with valid/ready on both sides;
  - a zero flag;
  - an illegal-opcode error flag;
  - an optional iterative multiplier.
- Sits between the operand/issue logic and the writeback stage of the datapath.

Parameters:
WIDTH, 32, operand/result width in bits (>= 4)

Ports:
clk        input   1      clock; all state updates on rising edge
reset      input   1      synchronous, active-high reset
in_valid   input   1      operands/opcode valid
in_ready   output  1      block accepts an operation this cycle
op         input   4      opcode: 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR, 8 MUL (optional), 9-15 illegal
a          input   WIDTH  operand A (two's complement or unsigned, per op)
b          input   WIDTH  operand B
out_valid  output  1      result/flags valid
out_ready  input   1      downstream accepts result
result     output  WIDTH  operation result
carryout   output  1      adder carry out (SUB: 1 = no borrow)
overflow   output  1      signed overflow (ADD/SUB); MUL: high half nonzero
zero       output  1      result == 0
err        output  1      illegal opcode for this build

Behaviour:
- Reset (clk edge with reset=1):
  - state <= IDLE;
  - out_valid, result, carryout, overflow, zero and err all <= 0.
  - Reset overrides any in-flight operation, including a multiply mid-iteration; the aborted op produces no output beat.
- Acceptance: a transfer occurs when in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - This gives full throughput for single-cycle ops when downstream is always ready.
- Single-cycle ops (0-7, illegal):
  - Outputs register on the accept edge; latency is 1 cycle.
  - Outputs hold stable while out_valid && !out_ready.
  - out_valid drops on the handshake edge unless a new op is accepted on that same edge.
- Arithmetic:
  - ADD: result = a+b mod 2^WIDTH; carryout = carry[WIDTH]; overflow = carry[WIDTH] ^ carry[WIDTH-1].
  - SUB: computed as a + ~b + 1, with flags defined the same way.
  - SLT: computes a-b internally; result = {0..., sub_msb ^ sub_overflow}, i.e. signed a<b; carryout = overflow = 0.
- Logic ops (XOR, AND, NAND, NOR, OR): bitwise; carryout = overflow = 0.
- zero is computed from the final registered result for every op, including MUL and illegal ops.
- Illegal opcode: result = 0, err = 1, carryout = overflow = 0, zero = 1. It still produces one output beat with latency 1.
- States:
  - IDLE: accepts ops.
  - MUL: iterating; in_ready = 0.
  - DONE: output pending.
  - For single-cycle ops, IDLE holds the output register directly; DONE is used only by MUL.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined: op 8 = unsigned multiply via shift-add.
  - On accept: state IDLE->MUL, counter <= 0, product accumulator <= 0.
  - Each cycle one multiplier bit is processed.
  - After exactly WIDTH cycles, state MUL->DONE with out_valid=1.
  - Latency from accept to out_valid is WIDTH+1 cycles.
  - Result = product[WIDTH-1:0]; overflow = |product[2*WIDTH-1:WIDTH]; carryout = 0; err = 0.
  - DONE->IDLE on the out_ready handshake.
  - An op presented during MUL/DONE is not accepted (in_ready=0) and must be held by the source.
- Undefined: op 8 is illegal (err=1, as above). No MUL state or accumulator is generated.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode localparams OP_ADD through OP_MUL;
  - state encoding constants IDLE/MUL/DONE.
- One natural sub-module, alu_seq_comb: combinational WIDTH-bit datapath for ops 0-7.
  - Inputs: a, b, op[2:0].
  - Outputs: result, carryout, overflow.
- alu_seq holds the handshake, state machine, output registers, zero/err logic and the optional multiplier.

Test Plan (WIDTH=32 unless noted):
- ADD/SUB flags:
  - ADD a=0x7FFFFFFF b=1 -> result 0x80000000, overflow 1, carryout 0, zero 0.
  - SUB a=5 b=5 -> result 0, carryout 1, overflow 0, zero 1.
- SLT:
  - a=0xFFFFFFFF (-1), b=1 -> result 1.
  - a=0x80000000, b=0x7FFFFFFF -> result 1 (overflow case).
  - a=3, b=-2 -> result 0.
- Backpressure: out_ready=0 for 3 cycles after an AND a=0xF0F0F0F0 b=0xFF00FF00.
  - result 0xF000F000 is held, in_ready=0, and a second queued op is not consumed.
  - The second op is accepted on the cycle out_ready rises.
- Illegal/back-to-back:
  - op=12 -> err 1, result 0, zero 1.
  - Streaming NOR, OR, NAND with out_ready=1 gives one result per cycle.
- MUL (ALU_SEQ_MUL_EN defined):
  - a=0x10000 b=0x10001 -> out_valid exactly 33 cycles after accept; result 0x00010000, overflow 1.
  - Without the macro: op=8 -> err 1 after 1 cycle.
- Reset mid-operation:
  - Assert reset 10 cycles into a MUL -> next cycle out_valid 0, in_ready 1.
  - No stale result appears afterwards.
